// File: rtl/timer_entry_ctrl.sv
// Keypad timer-entry sequencer: debounces coded keys, accepts one digit per press, builds MM:SS BCD.
// Optional macro TIMER_ENTRY_SEC_CHECK_EN: time_valid also requires seconds-tens <= 5.
module timer_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  kbd_code,
  input  logic        kbd_valid,
  input  logic        entry_en,
  input  logic        clear,
  output logic        kbd_en,
  output logic [15:0] time_bcd,
  output logic [2:0]  digit_count,
  output logic        key_strobe,
  output logic        overflow,
  output logic        time_valid
);
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  localparam logic [7:0] DC = 8'(DEBOUNCE_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]  r_code, w_code_nxt;
  logic        r_kbd_en;
  logic [15:0] r_bcd, w_bcd_nxt;
  logic [2:0]  r_digits, w_digits_nxt;
  logic        r_strobe, w_strobe_nxt;
  logic        r_ovf, w_ovf_nxt;
  logic        r_tv, w_tv_nxt;
  logic        w_valid, w_accept;

  // Samples are only trusted while the coder has been enabled for a full cycle.
  assign w_valid   = r_kbd_en & kbd_valid;
  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_accept    = 1'b0;
    if (!r_kbd_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_valid) begin
            w_code_nxt = kbd_code;
            if (DC == 8'd1) begin
              w_accept    = 1'b1;
              w_state_nxt = S_HELD;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_cnt_nxt   = 8'd1;
            end
          end
        S_DEBOUNCE:
          if (w_valid && kbd_code == r_code) begin
            if (w_cnt_inc == DC) begin
              w_accept    = 1'b1;
              w_state_nxt = S_HELD;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        S_HELD:
          if (!w_valid) begin
            // With a single-sample debounce the first invalid sample is already a full release.
            if (DC == 8'd1) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_state_nxt = S_RELEASE;
              w_cnt_nxt   = 8'd1;
            end
          end
        S_RELEASE:
          if (w_valid) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = 8'd0;
          end else if (w_cnt_inc == DC) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_bcd_nxt    = r_bcd;
    w_digits_nxt = r_digits;
    w_ovf_nxt    = r_ovf;
    w_strobe_nxt = 1'b0;
    if (clear) begin
      w_bcd_nxt    = 16'h0000;
      w_digits_nxt = 3'd0;
      w_ovf_nxt    = 1'b0;
    end else if (w_accept) begin
      if (r_digits < 3'd4) begin
        w_bcd_nxt    = {r_bcd[11:0], kbd_code};
        w_digits_nxt = r_digits + 3'd1;
        w_strobe_nxt = 1'b1;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
`ifdef TIMER_ENTRY_SEC_CHECK_EN
    w_tv_nxt = (w_digits_nxt != 3'd0) && (w_bcd_nxt != 16'h0000) && (w_bcd_nxt[7:4] <= 4'd5);
`else
    w_tv_nxt = (w_digits_nxt != 3'd0) && (w_bcd_nxt != 16'h0000);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_code   <= 4'd0;
      r_kbd_en <= 1'b0;
      r_bcd    <= 16'h0000;
      r_digits <= 3'd0;
      r_strobe <= 1'b0;
      r_ovf    <= 1'b0;
      r_tv     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_code   <= w_code_nxt;
      r_kbd_en <= entry_en;
      r_bcd    <= w_bcd_nxt;
      r_digits <= w_digits_nxt;
      r_strobe <= w_strobe_nxt;
      r_ovf    <= w_ovf_nxt;
      r_tv     <= w_tv_nxt;
    end
  end

  assign kbd_en      = r_kbd_en;
  assign time_bcd    = r_bcd;
  assign digit_count = r_digits;
  assign key_strobe  = r_strobe;
  assign overflow    = r_ovf;
  assign time_valid  = r_tv;
endmodule
